// File: rtl/lsu_pkg.sv
// Shared constants for the load/store path of the RV32I core.
// - acc_e       : memory access size driven by the control stage on
//                 mem_acc_r/mem_acc_w (NONE/B/H/W).
// - lsu_state_e : LSU access FSM states.
// - done_e      : what the LSU reports in its DONE cycle.
package lsu_pkg;

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_B    = 2'b01,
    ACC_H    = 2'b10,
    ACC_W    = 2'b11
  } acc_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_REQ    = 2'b01,
    S_WAIT_R = 2'b10,
    S_DONE   = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    DN_LOAD  = 2'b00,
    DN_STORE = 2'b01,
    DN_ERR   = 2'b10
  } done_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
// Request side (live decode in IDLE):
//   req_size, req_addr_lo, req_wdata -> req_be, req_wdata_rep, req_misaligned
// Response side (registered access in WAIT_R):
//   rsp_size, rsp_sext, rsp_addr_lo, rsp_rdata -> rsp_rdata_ext
module lsu_align
  import lsu_pkg::*;
(
  input  acc_e        req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  output logic        req_misaligned,
  input  acc_e        rsp_size,
  input  logic        rsp_sext,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata_ext
);

  logic [31:0] lane;

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    req_be         = 4'b0000;
    req_wdata_rep  = req_wdata;
    req_misaligned = 1'b0;
    case (req_size)
      ACC_B: begin
        req_be        = 4'b0001 << req_addr_lo;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      ACC_H: begin
        req_be         = 4'b0011 << req_addr_lo;
        req_wdata_rep  = {2{req_wdata[15:0]}};
        req_misaligned = req_addr_lo[0];
      end
      ACC_W: begin
        req_be         = 4'b1111;
        req_misaligned = (req_addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  // Move the addressed byte/half down to bit 0 before extending.
  assign lane = rsp_rdata >> {rsp_addr_lo, 3'b000};

  always_comb begin
    rsp_rdata_ext = rsp_rdata;
    case (rsp_size)
      ACC_B:   rsp_rdata_ext = {{24{rsp_sext & lane[7]}},  lane[7:0]};
      ACC_H:   rsp_rdata_ext = {{16{rsp_sext & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the control stage and a request/grant data bus.
// Control side : mem_wr_en_i, mem_acc_r_i, mem_acc_w_i, mem_r_sext_i, addr_i,
//                wdata_i in; rdata_o, rd_valid_o, wr_ready_o, stall_o, err_o out.
// Bus side     : bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o out;
//                bus_gnt_i, bus_rvalid_i, bus_rdata_i in.
// Accesses run IDLE -> REQ -> (WAIT_R) -> DONE; the core is stalled until
// DONE, where exactly one of rd_valid_o / wr_ready_o / err_o pulses.
// TIMEOUT_CYCLES bounds each of REQ and WAIT_R; 0 disables the bound.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        mem_wr_en_i,
  input  logic [1:0]  mem_acc_r_i,
  input  logic [1:0]  mem_acc_w_i,
  input  logic        mem_r_sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rd_valid_o,
  output logic        wr_ready_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  // Counter holds 0..TIMEOUT_CYCLES-1; the last value is the final waiting cycle.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_e  state_q, state_d;
  done_e       done_q, done_d;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] addr_q;
  acc_e        size_q;
  logic        sext_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  acc_e        acc_r, acc_w, req_size;
  logic        is_store, is_load, active;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic        req_misaligned;
  logic [31:0] rsp_rdata_ext;
  logic        timeout_hit;

  // A store wins when control presents both a store and a load.
  assign acc_r    = acc_e'(mem_acc_r_i);
  assign acc_w    = acc_e'(mem_acc_w_i);
  assign is_store = mem_wr_en_i && (acc_w != ACC_NONE);
  assign is_load  = !is_store && (acc_r != ACC_NONE);
  assign active   = is_store || is_load;
  assign req_size = is_store ? acc_w : acc_r;

  lsu_align u_align (
    .req_size       (req_size),
    .req_addr_lo    (addr_i[1:0]),
    .req_wdata      (wdata_i),
    .req_be         (req_be),
    .req_wdata_rep  (req_wdata_rep),
    .req_misaligned (req_misaligned),
    .rsp_size       (size_q),
    .rsp_sext       (sext_q),
    .rsp_addr_lo    (addr_q[1:0]),
    .rsp_rdata      (bus_rdata_i),
    .rsp_rdata_ext  (rsp_rdata_ext)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // A grant or read beat arriving in the final waiting cycle still counts;
  // the timeout fires only when that cycle passes with nothing from the bus.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (active) begin
          if (req_misaligned) begin
            state_d = S_DONE;
            done_d  = DN_ERR;
          end else begin
            state_d = S_REQ;
            done_d  = is_store ? DN_STORE : DN_LOAD;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT_R;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          done_d  = DN_ERR;
        end
      end
      S_WAIT_R: begin
        if (bus_rvalid_i) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          done_d  = DN_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // stall_o in IDLE is a direct function of the control inputs, so it is
  // also gated by reset to keep every output low while rstn_i is asserted.
  always_comb begin
    stall_o    = 1'b0;
    bus_req_o  = 1'b0;
    rd_valid_o = 1'b0;
    wr_ready_o = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      S_IDLE:   stall_o = active && rstn_i;
      S_REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
      end
      S_WAIT_R: stall_o = 1'b1;
      S_DONE: begin
        rd_valid_o = (done_q == DN_LOAD);
        wr_ready_o = (done_q == DN_STORE);
        err_o      = (done_q == DN_ERR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_q  <= DN_LOAD;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= ACC_NONE;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= done_d;

      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT_R) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // The bus-facing registers stay frozen from here until the next access.
      if (state_q == S_IDLE && active && !req_misaligned) begin
        addr_q  <= addr_i;
        size_q  <= req_size;
        sext_q  <= mem_r_sext_i;
        we_q    <= is_store;
        be_q    <= req_be;
        wdata_q <= req_wdata_rep;
      end

      if (state_q == S_WAIT_R && bus_rvalid_i) begin
        rdata_q <= rsp_rdata_ext;
      end
    end
  end

  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: randomized and directed accesses with a scoreboard. The
// driver pushes predicted bus transactions and responses; a negedge monitor
// compares them whenever the DUT requests the bus or reports completion.
// A second instance with TIMEOUT_CYCLES=4 exercises the timeout paths.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  always #5 clk_i = ~clk_i;

  logic        mem_wr_en_i, mem_r_sext_i;
  logic [1:0]  mem_acc_r_i, mem_acc_w_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        rd_valid_o, wr_ready_o, stall_o, err_o;
  logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;

  logic        t_wr_en, t_sext;
  logic [1:0]  t_acc_r, t_acc_w;
  logic [31:0] t_addr, t_wdata, t_rdata_o;
  logic        t_rd_valid, t_wr_ready, t_stall, t_err;
  logic        t_bus_req, t_bus_we, t_gnt, t_rvalid;
  logic [31:0] t_bus_addr, t_bus_wdata, t_bus_rdata;
  logic [3:0]  t_bus_be;

  lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .mem_wr_en_i(mem_wr_en_i), .mem_acc_r_i(mem_acc_r_i), .mem_acc_w_i(mem_acc_w_i),
    .mem_r_sext_i(mem_r_sext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rd_valid_o(rd_valid_o), .wr_ready_o(wr_ready_o),
    .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .mem_wr_en_i(t_wr_en), .mem_acc_r_i(t_acc_r), .mem_acc_w_i(t_acc_w),
    .mem_r_sext_i(t_sext), .addr_i(t_addr), .wdata_i(t_wdata),
    .rdata_o(t_rdata_o), .rd_valid_o(t_rd_valid), .wr_ready_o(t_wr_ready),
    .stall_o(t_stall), .err_o(t_err),
    .bus_req_o(t_bus_req), .bus_we_o(t_bus_we), .bus_addr_o(t_bus_addr),
    .bus_be_o(t_bus_be), .bus_wdata_o(t_bus_wdata),
    .bus_gnt_i(t_gnt), .bus_rvalid_i(t_rvalid), .bus_rdata_i(t_bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef enum int {K_NONE, K_LOAD, K_STORE, K_ERR} kind_e;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
  } rsp_exp_t;
  typedef struct {
    logic        wr_en;
    logic [1:0]  acc_r, acc_w;
    logic        sext;
    logic [31:0] addr, wdata, rdata;
    int          gnt_dly, rv_dly;
  } acc_t;

  bus_exp_t    bus_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] model_rdata;

  function automatic acc_t mk(input logic wr_en, input logic [1:0] acc_r, input logic [1:0] acc_w,
                              input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int g, input int r);
    acc_t a;
    a.wr_en = wr_en; a.acc_r = acc_r; a.acc_w = acc_w; a.sext = sext;
    a.addr = addr; a.wdata = wdata; a.rdata = rdata; a.gnt_dly = g; a.rv_dly = r;
    return a;
  endfunction

  // Reference model: outcome, bus transaction and latency from the access rules.
  task automatic predict(input acc_t a, output kind_e k, output logic [31:0] data,
                         output bus_exp_t b, output int retire);
    logic        store, load;
    logic [1:0]  size;
    int          off;
    logic [31:0] lane;
    store = a.wr_en && (a.acc_w != 2'd0);
    load  = !store && (a.acc_r != 2'd0);
    size  = store ? a.acc_w : a.acc_r;
    off   = int'(a.addr % 4);
    data  = 32'd0;
    b.we  = store;
    b.addr = a.addr - (a.addr % 4);
    b.be = 4'b1111;
    b.wdata = a.wdata;
    if (size == 2'd1) begin
      b.be = 4'(1 << off);
      b.wdata = (a.wdata & 32'hFF) * 32'h01010101;
    end else if (size == 2'd2) begin
      b.be = 4'(3 << off);
      b.wdata = (a.wdata & 32'hFFFF) * 32'h00010001;
    end
    lane = a.rdata >> (8 * off);
    if (size == 2'd1) begin
      data = lane & 32'hFF;
      if (a.sext && data >= 32'd128) data = data - 32'd256;
    end else if (size == 2'd2) begin
      data = lane & 32'hFFFF;
      if (a.sext && data >= 32'd32768) data = data - 32'd65536;
    end else begin
      data = a.rdata;
    end
    if (!store && !load) begin
      k = K_NONE; retire = 1;
    end else if ((size == 2'd2 && off % 2 != 0) || (size == 2'd3 && off != 0)) begin
      k = K_ERR; retire = 2;
    end else if (store) begin
      k = K_STORE; retire = 3 + a.gnt_dly;
    end else begin
      k = K_LOAD; retire = 4 + a.gnt_dly + a.rv_dly;
    end
  endtask

  task automatic clear_inputs();
    mem_wr_en_i = 1'b0; mem_acc_r_i = 2'd0; mem_acc_w_i = 2'd0; mem_r_sext_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;
  endtask

  // Drives one access, plays the bus slave with the requested delays and
  // measures when the core would retire the instruction (first unstalled cycle).
  task automatic run_access(input acc_t a);
    kind_e       k;
    logic [31:0] d;
    bus_exp_t    b;
    rsp_exp_t    r;
    int          exp_ret, cyc, stalls, req_seen, since;
    logic        gnt_done, rv_done, done;
    predict(a, k, d, b, exp_ret);
    if (k == K_LOAD || k == K_STORE) bus_q.push_back(b);
    if (k != K_NONE) begin
      r.kind = k; r.data = d;
      rsp_q.push_back(r);
    end
    @(posedge clk_i); #1;
    mem_wr_en_i = a.wr_en; mem_acc_r_i = a.acc_r; mem_acc_w_i = a.acc_w;
    mem_r_sext_i = a.sext; addr_i = a.addr; wdata_i = a.wdata;
    cyc = 1; stalls = 0; req_seen = 0; since = 0;
    gnt_done = 1'b0; rv_done = 1'b0; done = 1'b0;
    while (!done && cyc <= 64) begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom();
      if (gnt_done && !rv_done) begin
        since++;
        if (since == a.rv_dly + 1) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = a.rdata; rv_done = 1'b1;
        end
      end
      if (bus_req_o) begin
        if (req_seen == a.gnt_dly) begin
          bus_gnt_i = 1'b1; gnt_done = 1'b1;
        end
        req_seen++;
      end
      @(negedge clk_i);
      if (stall_o) stalls++;
      else         done = 1'b1;
      if (!done) begin
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    check("retire_cycle", 32'(cyc), 32'(exp_ret));
    check("stall_cycles", 32'(stalls), 32'(exp_ret - 1));
    @(posedge clk_i); #1;
    clear_inputs();
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (bus_req_o) begin
        check("bus_req_expected", 32'(bus_q.size() != 0), 32'd1);
        if (bus_q.size() != 0) begin
          check("bus_we",    32'(bus_we_o),   32'(bus_q[0].we));
          check("bus_addr",  bus_addr_o,      bus_q[0].addr);
          check("bus_be",    32'(bus_be_o),   32'(bus_q[0].be));
          if (bus_q[0].we) check("bus_wdata", bus_wdata_o, bus_q[0].wdata);
          if (bus_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (rd_valid_o || wr_ready_o || err_o) begin
        check("response_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          rsp_exp_t r;
          logic [2:0] exp_v;
          r = rsp_q.pop_front();
          exp_v = (r.kind == K_LOAD) ? 3'b100 : (r.kind == K_STORE) ? 3'b010 : 3'b001;
          check("response_kind", 32'({rd_valid_o, wr_ready_o, err_o}), 32'(exp_v));
          if (r.kind == K_LOAD) model_rdata = r.data;
        end
      end
    end
    check("rdata_hold", rdata_o, model_rdata);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    acc_t     a;
    bus_exp_t b;
    clear_inputs();
    t_wr_en = 1'b0; t_acc_r = 2'd0; t_acc_w = 2'd0; t_sext = 1'b0;
    t_addr = 32'd0; t_wdata = 32'd0; t_gnt = 1'b0; t_rvalid = 1'b0; t_bus_rdata = 32'd0;
    model_rdata = 32'd0;
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_stall",   32'(stall_o),   32'd0);
    check("reset_bus_req", 32'(bus_req_o), 32'd0);
    check("reset_outs",    32'({rd_valid_o, wr_ready_o, err_o}), 32'd0);
    check("reset_bus_addr", bus_addr_o, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Directed accesses.
    run_access(mk(1'b1, ACC_NONE, ACC_W, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0));
    run_access(mk(1'b1, ACC_NONE, ACC_B, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 0));
    run_access(mk(1'b0, ACC_B, ACC_NONE, 1'b1, 32'h103, 32'h0, 32'hA5000000, 0, 0));
    run_access(mk(1'b0, ACC_B, ACC_NONE, 1'b0, 32'h103, 32'h0, 32'hA5000000, 0, 0));
    run_access(mk(1'b0, ACC_H, ACC_NONE, 1'b1, 32'h102, 32'h0, 32'h80011234, 3, 0));
    run_access(mk(1'b0, ACC_W, ACC_NONE, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0));
    run_access(mk(1'b1, ACC_NONE, ACC_H, 1'b0, 32'h001, 32'h1234, 32'h0, 0, 0));
    run_access(mk(1'b1, ACC_B, ACC_W, 1'b1, 32'h104, 32'h01020304, 32'h0, 1, 0));
    run_access(mk(1'b0, ACC_H, ACC_NONE, 1'b0, 32'h100, 32'h0, 32'h1234F00D, 0, 2));

    // Reset while a load waits for read data.
    b.we = 1'b0; b.addr = 32'h200; b.be = 4'b1111; b.wdata = 32'h0;
    bus_q.push_back(b);
    @(posedge clk_i); #1;
    mem_acc_r_i = ACC_W; addr_i = 32'h200;
    @(posedge clk_i); #1;
    check("rst_test_req", 32'(bus_req_o), 32'd1);
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    check("rst_test_wait_stall", 32'(stall_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    model_rdata = 32'd0;
    #1;
    check("rst_async_bus_req", 32'(bus_req_o), 32'd0);
    check("rst_async_stall",   32'(stall_o),   32'd0);
    check("rst_async_outs",    32'({rd_valid_o, wr_ready_o, err_o}), 32'd0);
    check("rst_async_rdata",   rdata_o, 32'd0);
    bus_q.delete();
    rsp_q.delete();
    clear_inputs();
    @(negedge clk_i); #2;
    rstn_i = 1'b1;
    run_access(mk(1'b0, ACC_W, ACC_NONE, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 0, 0));

    // Randomized accesses, with stray read beats in idle cycles.
    for (int n = 0; n < 60; n++) begin
      a = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_access(a);
      if ($urandom_range(0, 1) == 1) begin
        bus_rvalid_i = 1'b1; bus_rdata_i = $urandom();
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
      end
    end

    // Timeout in WAIT_R: granted load, read data never arrives.
    @(posedge clk_i); #1;
    t_acc_r = ACC_W; t_addr = 32'h40;
    @(posedge clk_i); #1;
    check("to_load_req", 32'(t_bus_req), 32'd1);
    t_gnt = 1'b1;
    @(posedge clk_i); #1;
    t_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_stall", 32'(t_stall), 32'd1);
      check("to_wait_no_err", 32'(t_err), 32'd0);
      @(posedge clk_i); #1;
    end
    check("to_load_err",   32'(t_err),      32'd1);
    check("to_load_stall", 32'(t_stall),    32'd0);
    check("to_load_no_rv", 32'(t_rd_valid), 32'd0);
    t_acc_r = ACC_NONE;
    @(posedge clk_i); #1;
    check("to_idle_err", 32'(t_err), 32'd0);
    t_rvalid = 1'b1; t_bus_rdata = 32'h12345678;
    @(posedge clk_i); #1;
    t_rvalid = 1'b0;
    check("stray_rvalid_ignored", 32'(t_rd_valid), 32'd0);
    check("stray_rdata_unchanged", t_rdata_o, 32'd0);

    // Timeout in REQ: store never granted.
    t_wr_en = 1'b1; t_acc_w = ACC_W; t_addr = 32'h44; t_wdata = 32'h55AA55AA;
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", 32'(t_bus_req), 32'd1);
      @(posedge clk_i); #1;
    end
    check("to_req_dropped", 32'(t_bus_req), 32'd0);
    check("to_req_err",     32'(t_err),     32'd1);
    check("to_req_no_wr",   32'(t_wr_ready), 32'd0);
    t_wr_en = 1'b0; t_acc_w = ACC_NONE;
    @(posedge clk_i); #1;

    check("scoreboard_drained", 32'(bus_q.size() + rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
